// File: rtl/seq_alu.sv
// seq_alu: 8-bit execute unit. Logic/add ops finish in one cycle; shifts and
// multiply iterate one bit per cycle in RUN and report completion with DONE.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             START,
  input  logic [2:0]       OP,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic             CARRY,
  output logic             ZERO
);

  localparam int unsigned W       = WIDTH;
  localparam int unsigned SHAMT_W = 3;
  localparam int unsigned CNT_W   = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_SLL  = 3'b100;
  localparam logic [2:0] OP_SRL  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_SLTU = 3'b111;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [W-1:0]     sh_q, sh_d;
  logic [2*W-1:0]   mcand_q, mcand_d;
  logic [W-1:0]     mplier_q, mplier_d;
  logic [2*W-1:0]   prod_q, prod_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_d, done_d, carry_d, zero_d;
  logic [W-1:0]     result_d;

  logic [W:0]       sum;
  logic             fin, fin_carry, sh_out;
  logic [W-1:0]     fin_res, sh_next;
  logic [2*W-1:0]   prod_next;

  // Register stage: FSM state, iteration datapath and registered outputs.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      sh_q     <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      RESULT   <= '0;
      CARRY    <= 1'b0;
      ZERO     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sh_q     <= sh_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      BUSY     <= busy_d;
      DONE     <= done_d;
      RESULT   <= result_d;
      CARRY    <= carry_d;
      ZERO     <= zero_d;
    end
  end

  // Next-state, iteration step and completion values.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    sh_d      = sh_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    prod_d    = prod_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    result_d  = RESULT;
    carry_d   = CARRY;
    zero_d    = ZERO;
    sum       = '0;
    fin       = 1'b0;
    fin_res   = '0;
    fin_carry = 1'b0;
    sh_next   = sh_q;
    sh_out    = 1'b0;
    prod_next = prod_q;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          op_d     = OP;
          sh_d     = rs;
          mcand_d  = {{W{1'b0}}, rs};
          mplier_d = rt;
          prod_d   = '0;
          cnt_d    = CNT_W'(rt[SHAMT_W-1:0]);
          case (OP)
            OP_ADD: begin
              sum       = {1'b0, rs} + {1'b0, rt};
              fin       = 1'b1;
              fin_res   = sum[W-1:0];
              fin_carry = sum[W];
            end
            OP_SUB: begin
              // Carry out of rs + ~rt + 1 is the inverted borrow.
              sum       = {1'b0, rs} + {1'b0, ~rt} + {{W{1'b0}}, 1'b1};
              fin       = 1'b1;
              fin_res   = sum[W-1:0];
              fin_carry = sum[W];
            end
            OP_AND: begin
              fin     = 1'b1;
              fin_res = rs & rt;
            end
            OP_XOR: begin
              fin     = 1'b1;
              fin_res = rs ^ rt;
            end
            OP_SLL, OP_SRL: begin
              // A zero shift amount completes immediately with rs unchanged.
              if (rt[SHAMT_W-1:0] == '0) begin
                fin     = 1'b1;
                fin_res = rs;
              end else begin
                state_d = S_RUN;
              end
            end
            OP_MUL: begin
              cnt_d   = CNT_W'(W);
              state_d = S_RUN;
            end
            OP_SLTU: begin
              fin     = 1'b1;
              fin_res = (rs < rt) ? W'(1) : '0;
            end
          endcase
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        case (op_q)
          OP_SLL: begin
            sh_next = {sh_q[W-2:0], 1'b0};
            sh_out  = sh_q[W-1];
          end
          OP_SRL: begin
            sh_next = {1'b0, sh_q[W-1:1]};
            sh_out  = sh_q[0];
          end
          default: begin
            prod_next = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
          end
        endcase
        sh_d     = sh_next;
        prod_d   = prod_next;
        mcand_d  = {mcand_q[2*W-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[W-1:1]};
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          fin     = 1'b1;
          if (op_q == OP_MUL) begin
            fin_res   = prod_next[W-1:0];
            fin_carry = |prod_next[2*W-1:W];
          end else begin
            fin_res   = sh_next;
            fin_carry = sh_out;
          end
        end
      end
    endcase

    if (fin) begin
      done_d   = 1'b1;
      result_d = fin_res;
      carry_d  = fin_carry;
      zero_d   = (fin_res == '0);
    end
    busy_d = (state_d == S_RUN);
  end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: driver pushes model predictions, a monitor
// compares them against DONE completions, held outputs and BUSY.
module tb_seq_alu;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic       START;
  logic [2:0] OP;
  logic [7:0] rs, rt;
  logic       BUSY, DONE, CARRY, ZERO;
  logic [7:0] RESULT;

  seq_alu #(.WIDTH(8)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .OP(OP), .rs(rs), .rt(rt),
    .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT), .CARRY(CARRY), .ZERO(ZERO)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         due;
    logic [7:0] r;
    logic       c;
    logic       z;
  } exp_t;

  exp_t       q[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         acc_cyc = -100;
  int         cur_lat = 0;
  logic [7:0] hold_r = 8'h00;
  logic       hold_c = 1'b0;
  logic       hold_z = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model from the opcode definitions, plus cycles until DONE.
  task automatic model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] r, output logic c, output int lat);
    logic [15:0] t;
    int k;
    k   = int'(b[2:0]);
    c   = 1'b0;
    lat = 1;
    case (op)
      3'd0: begin t = a + b; r = t[7:0]; c = t[8]; end
      3'd1: begin r = a - b; c = (a >= b); end
      3'd2: r = a & b;
      3'd3: r = a ^ b;
      3'd4: begin
        t = {8'h00, a} << k; r = t[7:0];
        c = (k != 0) && t[8];
        lat = (k == 0) ? 1 : k + 1;
      end
      3'd5: begin
        r = a >> k;
        c = (k != 0) && a[k-1];
        lat = (k == 0) ? 1 : k + 1;
      end
      3'd6: begin t = a * b; r = t[7:0]; c = (t[15:8] != 8'h00); lat = 9; end
      default: r = (a < b) ? 8'h01 : 8'h00;
    endcase
  endtask

  // Drive START for one cycle and push the expected completion.
  task automatic launch(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        output int lat);
    exp_t e;
    model(op, a, b, e.r, e.c, lat);
    e.z     = (e.r == 8'h00);
    e.due   = cyc + lat;
    acc_cyc = cyc;
    cur_lat = lat;
    q.push_back(e);
    START = 1'b1; OP = op; rs = a; rt = b;
    @(negedge CLK);
    START = 1'b0;
    rs = 8'($urandom); rt = 8'($urandom);
  endtask

  // Full operation; optional noise on START/OP/operands while in RUN.
  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input bit noise);
    int lat;
    launch(op, a, b, lat);
    for (int i = 1; i < lat; i++) begin
      START = noise ? 1'($urandom) : 1'b0;
      OP = 3'($urandom); rs = 8'($urandom); rt = 8'($urandom);
      @(negedge CLK);
    end
    START = 1'b0;
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    START   = 1'b0;
    q.delete();
    hold_r  = 8'h00; hold_c = 1'b0; hold_z = 1'b0;
    cur_lat = 0;
    @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  // Monitor: completions, latency, held outputs and BUSY window.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (q.size() > 0 && q[0].due < cyc && !DONE) begin
        e = q.pop_front();
        chk("done_timeout", cyc, e.due);
      end
      if (DONE) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk("done_cycle", cyc, e.due);
          hold_r = e.r; hold_c = e.c; hold_z = e.z;
        end
      end
      chk("result", int'(RESULT), int'(hold_r));
      chk("carry", int'(CARRY), int'(hold_c));
      chk("zero", int'(ZERO), int'(hold_z));
      chk("busy", int'(BUSY), int'((cyc > acc_cyc) && (cyc < acc_cyc + cur_lat)));
      chk("busy_and_done", int'(BUSY && DONE), 0);
    end
  end

  initial begin
    int lat;
    logic [2:0] op;
    RESET_N = 1'b0; START = 1'b0; OP = 3'd0; rs = 8'h00; rt = 8'h00;
    repeat (3) @(negedge CLK);
    chk("reset_result", int'(RESULT), 0);
    chk("reset_flags", int'({BUSY, DONE, CARRY, ZERO}), 0);
    RESET_N = 1'b1;
    @(negedge CLK);

    issue(3'd0, 8'hF0, 8'h20, 1'b0);
    @(negedge CLK);
    issue(3'd1, 8'h05, 8'h05, 1'b0);
    issue(3'd1, 8'h03, 8'h05, 1'b0);
    issue(3'd4, 8'h81, 8'h03, 1'b0);
    issue(3'd5, 8'h81, 8'h01, 1'b0);
    @(negedge CLK);

    // MUL with operands changed and START re-pulsed in cycle 4.
    launch(3'd6, 8'h10, 8'h11, lat);
    repeat (3) @(negedge CLK);
    START = 1'b1; OP = 3'd0; rs = 8'hFF; rt = 8'hFF;
    @(negedge CLK);
    START = 1'b0;
    repeat (4) @(negedge CLK);
    @(negedge CLK);

    // Reset in cycle 5 of a MUL: no DONE may follow.
    launch(3'd6, 8'hAB, 8'hCD, lat);
    repeat (4) @(negedge CLK);
    do_reset();
    repeat (10) @(negedge CLK);
    issue(3'd7, 8'h01, 8'h02, 1'b0);
    issue(3'd4, 8'h5A, 8'h08, 1'b0);
    issue(3'd7, 8'h02, 8'h01, 1'b0);
    issue(3'd2, 8'hF0, 8'h0F, 1'b0);

    for (int n = 0; n < 200; n++) begin
      op = 3'($urandom);
      issue(op, 8'($urandom), 8'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge CLK);
    chk("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Multi-cycle 8-bit execute unit directly downstream of the register file. It consumes the `rs`/`rt` operand values the register file drives and produces the `RESULT` word that returns to the register file's `write_value` input. Single-cycle logic/arithmetic ops complete in one cycle; shifts and multiply iterate one bit per cycle under a small FSM. Completion is signalled by a `DONE` pulse, which control uses to assert `REGWRITE`.

## Interface

- `WIDTH`, default 8: datapath width. Only 8 is verified.
- `CLK` in 1: sole clock, rising edge.
- `RESET_N` in 1: reset, synchronous, active-low.
- `START` in 1: request to begin an operation; sampled only in IDLE.
- `OP` in 3: opcode; latched on an accepted `START`.
- `rs` in WIDTH: operand A, from register file `rs`; latched on an accepted `START`.
- `rt` in WIDTH: operand B, from register file `rt`; latched on an accepted `START`.
- `BUSY` out 1: high while the FSM is in RUN.
- `DONE` out 1: one-cycle pulse; `RESULT`/`CARRY`/`ZERO` are valid from this cycle onward.
- `RESULT` out WIDTH: operation result; held until the next completion.
- `CARRY` out 1: per-op flag, defined below; held until the next completion.
- `ZERO` out 1: high when `RESULT == 0`; updated with `RESULT`.

## Operation

- FSM states: IDLE and RUN. `DONE` is a registered pulse, not a state.
- Opcodes, results and `CARRY`:
  - 000 ADD: `RESULT = rs + rt` mod 256. `CARRY` = bit 8 of the sum.
  - 001 SUB: `RESULT = rs + ~rt + 1` mod 256. `CARRY` = bit 8, so 1 = no borrow (`rs >= rt`).
  - 010 AND: `CARRY` = 0.
  - 011 XOR: `CARRY` = 0.
  - 100 SLL: shift `rs` left by `rt[2:0]`, one bit per RUN cycle. `CARRY` = last bit shifted out; 0 if the amount is 0.
  - 101 SRL: logical right shift by `rt[2:0]`, otherwise as SLL. `CARRY` = last bit shifted out.
  - 110 MUL: unsigned shift-add, 8 RUN cycles. `RESULT` = low byte. `CARRY` = 1 if the high byte is nonzero.
  - 111 SLTU: `RESULT` = 1 if `rs < rt` unsigned, else 0. `CARRY` = 0.
- IDLE, `START` = 1:
  - Latch `OP`, `rs`, `rt`.
  - Ops 000–011, 111, and shifts with amount 0: compute and register outputs at this edge; stay in IDLE; `DONE` = 1 next cycle.
  - Shifts with amount k ≥ 1, and MUL: load the iteration counter (k, or 8) and go to RUN.
- RUN:
  - One iteration per cycle; the counter decrements.
  - On the last iteration, register outputs, go to IDLE, and assert `DONE` the following cycle.
- `START` while in RUN is ignored: no queueing, operands not re-latched.
- `START` during the `DONE` cycle (state IDLE) is accepted, so back-to-back ops have no bubble.
- The `rs`/`rt` inputs may change after acceptance without affecting the operation in flight.

## Timing

- Reset (`RESET_N` = 0 at a rising edge) forces: state IDLE, `BUSY` 0, `DONE` 0, `RESULT` 0x00, `CARRY` 0, `ZERO` 0, counter 0.
- `RESET_N` has priority over `START` in the same cycle.
- Reset during RUN aborts the operation; no `DONE` is produced afterwards.
- Latency, with `START` accepted in cycle 0:
  - Single-cycle ops: `DONE` in cycle 1.
  - Shift by k: `DONE` in cycle k+1; `BUSY` high in cycles 1..k.
  - MUL: `DONE` in cycle 9; `BUSY` high in cycles 1..8.
- `DONE` is high for exactly one cycle per accepted `START`.
- `BUSY` and `DONE` are never high together.
- `RESULT`, `CARRY` and `ZERO` change only at a completion edge or at reset.

## Test plan

- ADD: `rs` = 0xF0, `rt` = 0x20, `START` in cycle 0 → cycle 1: `DONE` = 1, `RESULT` = 0x10, `CARRY` = 1, `ZERO` = 0, `BUSY` never 1.
- SUB:
  - 0x05 − 0x05 → `RESULT` 0x00, `ZERO` 1, `CARRY` 1.
  - Back-to-back in the `DONE` cycle, 0x03 − 0x05 → `RESULT` 0xFE, `CARRY` 0, `DONE` 1 cycle after the second `START`.
- SLL: `rs` = 0x81, `rt` = 0x03 → `BUSY` cycles 1–3, cycle 4: `DONE`, `RESULT` 0x08, `CARRY` 0. Also SRL of 0x81 by 1 → `RESULT` 0x40, `CARRY` 1, `DONE` in cycle 2.
- MUL: 0x10 × 0x11, with `rs`/`rt` changed and `START` re-pulsed in cycle 4 → single `DONE` in cycle 9, `RESULT` 0x10, `CARRY` 1. The cycle-4 `START` is ignored.
- Reset: `RESET_N` low in cycle 5 of a MUL → all outputs 0 the next cycle, no `DONE` for the next 10 cycles. A fresh SLTU with 0x01, 0x02 → `RESULT` 0x01 in the following cycle.
- Shift by 0: SLL with `rt` = 0x08 (amount 0) → `DONE` in cycle 1, `RESULT` = `rs`, `CARRY` 0, `BUSY` never 1.
